// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, frame constants and parity helper
// Used by both the host transmit path and the device-to-host receive path.
package ps2_pkg;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  // Odd parity bit: makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] value);
    return ~^value;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchroniser, optional glitch filter, falling-edge pulse
// Ports:
//   i_clock, i_reset : system clock, synchronous active-high reset
//   i_pin            : raw asynchronous pin level
//   o_level          : synchronised (and, if enabled, filtered) level
//   o_fall           : one-cycle pulse on a high-to-low change of o_level
module ps2_line_sync #(
  parameter bit FILTER_EN     = 1'b1,
  parameter int FILTER_CYCLES = 8
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  logic sync1_q;
  logic sync2_q;

  // Idle PS/2 lines are pulled high, so the synchroniser resets to 1.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_pin;
      sync2_q <= sync2_q == sync1_q ? sync2_q : sync1_q;
    end
  end

  generate
    if (FILTER_EN) begin : g_filter
      localparam int CW = $clog2(FILTER_CYCLES + 1);

      logic [CW-1:0] cnt_q;
      logic          level_q;
      logic          fall_q;

      // A new level is accepted only after FILTER_CYCLES consecutive
      // samples disagree with the current one; any agreeing sample restarts.
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          cnt_q   <= '0;
          level_q <= 1'b1;
          fall_q  <= 1'b0;
        end else begin
          fall_q <= 1'b0;
          if (sync2_q == level_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
            fall_q  <= level_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign o_level = level_q;
      assign o_fall  = fall_q;
    end else begin : g_direct
      logic prev_q;

      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          prev_q <= 1'b1;
        end else begin
          prev_q <= sync2_q;
        end
      end

      assign o_level = sync2_q;
      assign o_fall  = prev_q & ~sync2_q;
    end
  endgenerate

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Ports:
//   i_clock, i_reset           : system clock, synchronous active-high reset
//   i_data, i_valid, o_ready   : command byte handshake (ready only when idle)
//   i_ps2_clk, i_ps2_dat       : raw pin levels (asynchronous)
//   o_ps2_clk_oe, o_ps2_dat_oe : 1 = pull the line low (open drain)
//   o_done, o_error            : end-of-transfer pulse; error = no ack or timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * 15,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  output logic       o_done,
  output logic       o_error
);

  localparam logic [19:0] INHIBIT_LOAD = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LOAD = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LAST_SEND    = 4'(PS2_FRAME_BITS - 2);

  ps2_state_e  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  edge_cnt_q, edge_cnt_d;
  logic [8:0]  shift_q, shift_d;
  logic        dat_oe_q, dat_oe_d;
  logic        err_q, err_d;
  logic        done_c, error_c, timeout_hit;

  logic        clk_level, clk_fall;
  logic        dat_level, dat_fall_unused;

  ps2_line_sync #(
    .FILTER_EN     (1'b1),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_clk_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_pin   (i_ps2_clk),
    .o_level (clk_level),
    .o_fall  (clk_fall)
  );

  ps2_line_sync #(
    .FILTER_EN     (1'b0),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_dat_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_pin   (i_ps2_dat),
    .o_level (dat_level),
    .o_fall  (dat_fall_unused)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      shift_q    <= '0;
      dat_oe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      shift_q    <= shift_d;
      dat_oe_q   <= dat_oe_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_cnt_d  = edge_cnt_q;
    shift_d     = shift_q;
    dat_oe_d    = dat_oe_q;
    err_d       = err_q;
    done_c      = 1'b0;
    error_c     = 1'b0;
    timeout_hit = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d  = ST_INHIBIT;
          cnt_d    = INHIBIT_LOAD;
          shift_d  = {odd_parity(i_data), i_data};
          dat_oe_d = 1'b0;
          err_d    = 1'b0;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == '0) begin
          state_d  = ST_REQ;
          dat_oe_d = 1'b1;          // start bit
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      ST_REQ: begin
        state_d    = ST_SEND;
        cnt_d      = TIMEOUT_LOAD;  // same counter now times the device
        edge_cnt_d = '0;
      end

      ST_SEND, ST_ACK: begin
        if (cnt_q == '0) begin
          timeout_hit = 1'b1;
          done_c      = 1'b1;
          error_c     = 1'b1;
          dat_oe_d    = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 20'd1;
          if (clk_fall) begin
            edge_cnt_d = edge_cnt_q + 4'd1;
            if (state_q == ST_SEND) begin
              // Shifting in ones makes the 10th edge present the stop bit.
              dat_oe_d = ~shift_q[0];
              shift_d  = {1'b1, shift_q[8:1]};
              if (edge_cnt_q == LAST_SEND) begin
                state_d = ST_ACK;
              end
            end else begin
              err_d   = dat_level;  // device holds data low to acknowledge
              state_d = ST_WAIT_IDLE;
            end
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_level && dat_level) begin
          done_c  = 1'b1;
          error_c = err_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign o_ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
  // On timeout the data line is released in the same cycle as o_done.
  assign o_ps2_dat_oe = dat_oe_q & ~timeout_hit;
  assign o_done       = done_c & ~i_reset;
  assign o_error      = error_c & ~i_reset;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard testbench for ps2_host_tx against a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TO   = 6000;
  localparam int HALF = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready, clk_oe, dat_oe, done, error;
  logic       dev_clk_lo = 1'b0;
  logic       dev_dat_lo = 1'b0;

  wire ps2_clk_pin = ~(clk_oe | dev_clk_lo);
  wire ps2_dat_pin = ~(dat_oe | dev_dat_lo);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_data       (data),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_ps2_clk    (ps2_clk_pin),
    .i_ps2_dat    (ps2_dat_pin),
    .o_ps2_clk_oe (clk_oe),
    .o_ps2_dat_oe (dat_oe),
    .o_done       (done),
    .o_error      (error)
  );

  typedef struct {
    logic [9:0] frame;      // {stop, parity, d7..d0} as seen on the line
    bit         chk_frame;
    bit         err;
    int         lat;        // cycles from REQ to done, 0 = not checked
  } exp_t;

  exp_t       sb_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         req_cyc     = 0;
  int         done_seen   = 0;
  logic [9:0] dev_cap     = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation for every o_done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (clk_oe && dat_oe) req_cyc = cyc;
      if (done) begin
        done_seen++;
        check("done_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("done_error", error, e.err);
          check("done_enables", {clk_oe, dat_oe}, 2'b00);
          if (e.chk_frame) check("frame_bits", dev_cap, e.frame);
          if (e.lat > 0) check("timeout_latency", cyc - req_cyc, e.lat);
          @(negedge clk);
          check("ready_after_done", {ready, done}, 2'b10);
        end
      end
    end
  end

  // Host clock hold must last INHIBIT + 1 cycles every transfer.
  initial begin : oe_width
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (clk_oe) w++;
      else if (w > 0) begin
        check("clk_oe_width", w, INH + 1);
        w = 0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    data  = b;
    valid = 1'b1;
    while (!ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", ready, 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Device model: waits for request-to-send, clocks `falls` edges and samples
  // data on each rising edge. With falls < 11 it returns holding clock low.
  task automatic dev_frame(input bit ack, input int falls);
    int n;
    logic [9:0] f;
    n = 0;
    while (!clk_oe && n < 20000) begin @(negedge clk); n++; end
    check("rts_clk_low", clk_oe, 1);
    n = 0;
    while (clk_oe && n < INH + 20) begin @(negedge clk); n++; end
    check("rts_release", clk_oe, 0);
    check("start_bit", ps2_dat_pin, 0);
    repeat (40) @(negedge clk);
    f = '0;
    for (int i = 1; i <= falls; i++) begin
      if (i == 11 && ack) begin
        dev_dat_lo = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_lo = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i <= 10) f[i-1] = ps2_dat_pin;
      if (i == 10) dev_cap = f;
      if (i == falls && falls < 11) return;
      dev_clk_lo = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_dat_lo = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (!ready && n < bound) begin @(negedge clk); n++; end
    check("return_idle", ready, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] b, input logic [9:0] frame, input bit ack);
    sb_q.push_back('{frame, 1'b1, ~ack, 0});
    fork
      send(b);
      dev_frame(ack, 11);
    join
    wait_idle(500);
  endtask

  initial begin : stimulus
    int n;
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ready, clk_oe, dat_oe, done, error}, 5'b10000);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_outputs", {ready, clk_oe, dat_oe, done, error}, 5'b10000);

    // 0xED: six ones -> parity 1; 0x01: one -> parity 0; 0x55 refused by device
    xfer(8'hED, 10'h3ED, 1'b1);
    xfer(8'h01, 10'h201, 1'b1);
    xfer(8'h55, 10'h355, 1'b0);

    // Silent device: timeout TO cycles after REQ
    sb_q.push_back('{10'h000, 1'b0, 1'b1, TO});
    send(8'hFF);
    wait_idle(TO + INH + 200);

    // 0xAA held valid while 0xFF is in flight; must follow as a separate frame
    sb_q.push_back('{10'h3FF, 1'b1, 1'b0, 0});
    sb_q.push_back('{10'h3AA, 1'b1, 1'b0, 0});
    fork
      begin
        send(8'hFF);
        data  = 8'hAA;
        valid = 1'b1;
        n = 0;
        while (!ready && n < 5000) begin @(negedge clk); n++; end
        check("held_accept_ready", ready, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
      end
      begin
        dev_frame(1'b1, 11);
        dev_frame(1'b1, 11);
      end
    join
    wait_idle(500);

    // Reset after the 5th falling edge of 0x0F (d4 = 0 -> data pulled low)
    fork
      send(8'h0F);
      dev_frame(1'b1, 5);
    join
    check("dat_oe_bit4", dat_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_midframe", {clk_oe, dat_oe, done}, 3'b000);
    rst        = 1'b0;
    dev_clk_lo = 1'b0;
    repeat (30) @(negedge clk);
    check("ready_after_reset", ready, 1);

    // 0xF4: five ones -> parity 0
    xfer(8'hF4, 10'h2F4, 1'b1);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("done_count", done_seen, 7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
